fft_ram_sequencer: RTL
======================

FFT_RAM_SEQUENCER -- requirements
Module: fft_ram_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width (N = 2^ADDR_W points).
REQ-002 SHALL have parameter DATA_W, default 14, sample/RAM word width.
REQ-003 SHALL have parameter AFIFO_D, default 8, outstanding-butterfly address FIFO depth.
REQ-004 clk  in  1  single clock, all logic on rising edge; reset is asynchronous and active-low.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a transform; ignored unless IDLE.
REQ-007 s_tdata  in  DATA_W  input sample.
REQ-008 s_tvalid  in  1  input sample valid.
REQ-009 s_tready  out  1  high only in LOAD.
REQ-010 ram_addra, ram_addrb  out  ADDR_W  RAM port addresses, registered.
REQ-011 ram_wea, ram_web  out  1  RAM port write enables, registered.
REQ-012 ram_dina  out  DATA_W  port-a write data (LOAD only).
REQ-013 bf_in_valid  out  1  RAM read pair is present on douta/doutb this cycle.
REQ-014 bf_tw_addr  out  ADDR_W-1  twiddle index aligned with bf_in_valid.
REQ-015 bf_out_valid  in  1  butterfly result pair ready; butterfly drives RAM dina/dinb in CALC.
REQ-016 m_tvalid, m_tlast  out  1  output stream valid; last at index N-1.
REQ-017 busy, done  out  1  busy high outside IDLE; done is a one-cycle pulse at end of OUT.

Function
REQ-018 States: IDLE, LOAD, CALC, FLUSH, OUT; IDLE->LOAD on start.
REQ-019 LOAD: each s_tvalid&&s_tready accepts sample k (k=0..N-1) and SHALL write it via port a to address bitrev(k) on the next cycle; sample N-1 accepted -> CALC.
REQ-020 CALC, stage s (0..ADDR_W-1), butterfly j (0..N/2-1): span=2^s, p=(j/span)*2*span + (j mod span); read addra=p, addrb=p+span; tw=(j mod span)<<(ADDR_W-1-s).
REQ-021 Read pair issue SHALL push {p, p+span} into the address FIFO; bf_in_valid and bf_tw_addr SHALL assert exactly 1 cycle after issue (RAM read latency 1).
REQ-022 bf_out_valid SHALL pop the FIFO and write back in place on both ports the next cycle (wea=web=1); writeback has priority, read issue is suppressed that cycle.
REQ-023 Reads SHALL stall while the FIFO is full; bf_out_valid with FIFO empty SHALL be ignored (no write).
REQ-024 After last read of a stage -> FLUSH; FLUSH waits for FIFO empty, then next stage in CALC, or OUT after stage ADDR_W-1.
REQ-025 OUT: read addresses 0..N-1 on port a, one per cycle; m_tvalid 1 cycle after each address; m_tlast with index N-1; done pulses with m_tlast; next cycle IDLE.
REQ-026 Counters SHALL wrap naturally at ADDR_W bits; no address SHALL exceed N-1.
REQ-027 start during busy, s_tvalid outside LOAD: ignored, no RAM write.

Reset
REQ-028 rst_n low SHALL force IDLE, clear FIFO and counters, and drive all outputs 0 asynchronously, including mid-transform; RAM contents are not cleared.
REQ-029 First start after reset release SHALL run a complete transform.

Structure
REQ-030 State encoding, ADDR_W/DATA_W defaults and bit-reverse function SHALL live in shared package fft_pkg.
REQ-031 The address FIFO SHALL be a sub-module addr_fifo (synchronous, depth AFIFO_D, full/empty flags).

Verification
REQ-032 N=1024, samples k=0..1023 value k -> writes observed at bitrev(k), e.g. k=1 at 512, k=3 at 768.
REQ-033 Butterfly model latency 4, impulse at index 0 -> 10 stages, output stream 1024 equal words, m_tlast and done at index 1023.
REQ-034 Stage 2, j=5 -> addra=9, addrb=13, bf_tw_addr=128.
REQ-035 Butterfly latency 12 (> AFIFO_D) -> reads stall on full, no lost or duplicated writeback, result matches reference FFT.
REQ-036 rst_n low in CALC stage 5 -> all outputs 0 immediately; new start -> correct full transform.
REQ-037 start pulse during CALC and s_tvalid in IDLE -> no state change, no RAM write.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 FFT RAM sequencer:
// state encoding, parameter defaults and the bit-reverse helper.
package fft_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned DATA_W_DEF   = 14;
    localparam int unsigned AFIFO_D_DEF  = 8;
    localparam int unsigned BITREV_MAX_W = 16;
    localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_OUT   = 3'd4
    } seq_state_e;

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                       input int unsigned w);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < w) begin
                r[BITREV_IDX_W'(i)] = x[BITREV_IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_fifo.sv
// Synchronous FIFO holding the address pairs of butterflies whose results
// have not yet been written back. Head entry is visible without a pop.
module addr_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/fft_ram_sequencer.sv
// Address/control sequencer for an in-place radix-2 FFT on an external
// dual-port RAM: bit-reversed load, stage-by-stage butterflies, streamed output.
module fft_ram_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned AFIFO_D = AFIFO_D_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_wea,
    output logic              ram_web,
    output logic [DATA_W-1:0] ram_dina,
    output logic              bf_in_valid,
    output logic [ADDR_W-2:0] bf_tw_addr,
    input  logic              bf_out_valid,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              busy,
    output logic              done
);

    localparam int unsigned J_W    = ADDR_W - 1;
    localparam int unsigned STG_W  = $clog2(ADDR_W + 1);
    localparam int unsigned PAIR_W = 2 * ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX   = '1;
    localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(ADDR_W - 1);

    seq_state_e        state;
    logic [ADDR_W-1:0] cnt;
    logic [J_W-1:0]    j;
    logic [STG_W-1:0]  stage;
    logic              issue_q;
    logic [J_W-1:0]    tw_q;
    logic              out_q;
    logic              last_q;

    logic [ADDR_W-1:0] j_ext;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] p_a;
    logic [ADDR_W-1:0] p_b;
    logic [J_W-1:0]    tw;
    logic              wb_take;
    logic              rd_issue;
    logic [PAIR_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    // Butterfly j of the current stage: pair (p, p+span) and its twiddle index.
    always_comb begin
        j_ext    = ADDR_W'(j);
        span     = ADDR_W'(1) << stage;
        mask     = span - 1'b1;
        p_a      = ((j_ext >> stage) << (stage + 1'b1)) | (j_ext & mask);
        p_b      = p_a | span;
        tw       = J_W'((j_ext & mask) << (J_W - stage));
        wb_take  = ((state == ST_CALC) || (state == ST_FLUSH)) && bf_out_valid && !fifo_empty;
        rd_issue = (state == ST_CALC) && !wb_take && !fifo_full;
    end

    addr_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (AFIFO_D)
    ) u_addr_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (rd_issue),
        .din    ({p_a, p_b}),
        .pop    (wb_take),
        .head_c (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            j           <= '0;
            stage       <= '0;
            issue_q     <= 1'b0;
            tw_q        <= '0;
            out_q       <= 1'b0;
            last_q      <= 1'b0;
            s_tready    <= 1'b0;
            ram_addra   <= '0;
            ram_addrb   <= '0;
            ram_wea     <= 1'b0;
            ram_web     <= 1'b0;
            ram_dina    <= '0;
            bf_in_valid <= 1'b0;
            bf_tw_addr  <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_wea     <= 1'b0;
            ram_web     <= 1'b0;
            issue_q     <= 1'b0;
            out_q       <= 1'b0;
            last_q      <= 1'b0;
            // RAM read latency is one cycle: qualifiers trail their address by one.
            bf_in_valid <= issue_q;
            bf_tw_addr  <= tw_q;
            m_tvalid    <= out_q;
            m_tlast     <= last_q;
            done        <= last_q;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        s_tready <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                end

                ST_LOAD: begin
                    if (s_tvalid && s_tready) begin
                        ram_wea   <= 1'b1;
                        ram_addra <= ADDR_W'(bitrev(BITREV_MAX_W'(cnt), ADDR_W));
                        ram_dina  <= s_tdata;
                        cnt       <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            s_tready <= 1'b0;
                            state    <= ST_CALC;
                            stage    <= '0;
                            j        <= '0;
                        end
                    end
                end

                ST_CALC, ST_FLUSH: begin
                    if (wb_take) begin
                        ram_addra <= fifo_head[PAIR_W-1 -: ADDR_W];
                        ram_addrb <= fifo_head[ADDR_W-1:0];
                        ram_wea   <= 1'b1;
                        ram_web   <= 1'b1;
                    end else if (rd_issue) begin
                        ram_addra <= p_a;
                        ram_addrb <= p_b;
                        tw_q      <= tw;
                        issue_q   <= 1'b1;
                        j         <= j + 1'b1;
                        if (j == '1) state <= ST_FLUSH;
                    end else if ((state == ST_FLUSH) && fifo_empty) begin
                        if (stage == LAST_STAGE) begin
                            state <= ST_OUT;
                            cnt   <= '0;
                        end else begin
                            stage <= stage + 1'b1;
                            state <= ST_CALC;
                        end
                    end
                end

                ST_OUT: begin
                    // last_q marks the cycle m_tlast/done go out; leave right after.
                    if (last_q) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ram_addra <= cnt;
                        out_q     <= 1'b1;
                        last_q    <= (cnt == LAST_IDX);
                        cnt       <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
